// File: rtl/tmds_pkg.sv
`default_nettype none
// ============================================================================
// tmds_pkg : shared TMDS symbol constants, disparity type and popcount helper.
// Rev 1.0
// ============================================================================
package tmds_pkg;

  localparam int SYM_W = 10;

  localparam logic [SYM_W-1:0] CTRL_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_11 = 10'b1010101011;

  typedef logic signed [4:0] disp_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_qm_encode.sv
`default_nettype none
// ============================================================================
// tmds_qm_encode : combinational transition-minimisation (stage 1 of TMDS).
// Rev 1.0
// ============================================================================
module tmds_qm_encode
  import tmds_pkg::*;
(
  input  logic [7:0] i_data,
  output logic [8:0] o_qm,
  output logic [3:0] o_n1q
);

  logic [3:0] w_n1d;
  logic       w_use_xnor;
  logic [8:0] w_qm;

  always_comb begin
    w_n1d      = popcount8(i_data);
    w_use_xnor = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !i_data[0]);
    w_qm       = '0;
    w_qm[0]    = i_data[0];
    for (int i = 1; i < 8; i++) begin
      w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ i_data[i]) : (w_qm[i-1] ^ i_data[i]);
    end
    w_qm[8] = ~w_use_xnor;
  end

  assign o_qm  = w_qm;
  assign o_n1q = popcount8(w_qm[7:0]);

endmodule
`default_nettype wire

// File: rtl/tmds_encoder.sv
`default_nettype none
// ============================================================================
// tmds_encoder : 2-stage DC-balanced DVI TMDS encoder for one colour channel.
// Define TMDS_ENCODER_DBG_EN to expose o_disparity and a disparity-bound check.
// Rev 1.0
// ============================================================================
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter bit OUT_LSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_data,
  input  logic             i_de,
  input  logic             i_c0,
  input  logic             i_c1,
  output logic [SYM_W-1:0] o_tmds
`ifdef TMDS_ENCODER_DBG_EN
  ,
  output logic signed [4:0] o_disparity
`endif
);

  logic [8:0]       w_qm;
  logic [3:0]       w_n1q;

  logic [8:0]       r_qm;
  logic [3:0]       r_n1q;
  logic             r_de;
  logic             r_c0;
  logic             r_c1;
  disp_t            r_cnt;
  logic [SYM_W-1:0] r_tmds;

  disp_t            w_n1q_s;
  disp_t            w_n0q_s;
  disp_t            w_diff;
  disp_t            w_cnt_nxt;
  logic [SYM_W-1:0] w_sym;
  logic [SYM_W-1:0] w_sym_out;
  logic [SYM_W-1:0] w_ctrl_rst;

  tmds_qm_encode u_qm (
    .i_data (i_data),
    .o_qm   (w_qm),
    .o_n1q  (w_n1q)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_qm  <= '0;
      r_n1q <= '0;
      r_de  <= 1'b0;
      r_c0  <= 1'b0;
      r_c1  <= 1'b0;
    end else begin
      r_qm  <= w_qm;
      r_n1q <= w_n1q;
      r_de  <= i_de;
      r_c0  <= i_c0;
      r_c1  <= i_c1;
    end
  end

  // w_diff is n1q - n0q; every branch below is expressed in terms of it.
  assign w_n1q_s = disp_t'({1'b0, r_n1q});
  assign w_n0q_s = 5'sd8 - w_n1q_s;
  assign w_diff  = w_n1q_s - w_n0q_s;

  always_comb begin
    w_sym     = CTRL_00;
    w_cnt_nxt = r_cnt;
    if (!r_de) begin
      case ({r_c1, r_c0})
        2'b00:   w_sym = CTRL_00;
        2'b01:   w_sym = CTRL_01;
        2'b10:   w_sym = CTRL_10;
        default: w_sym = CTRL_11;
      endcase
      w_cnt_nxt = 5'sd0;
    end else if ((r_cnt == 5'sd0) || (w_n1q_s == w_n0q_s)) begin
      w_sym     = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
      w_cnt_nxt = r_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
    end else if (((r_cnt > 5'sd0) && (w_n1q_s > w_n0q_s)) ||
                 ((r_cnt < 5'sd0) && (w_n0q_s > w_n1q_s))) begin
      w_sym     = {1'b1, r_qm[8], ~r_qm[7:0]};
      w_cnt_nxt = r_cnt + (r_qm[8] ? 5'sd2 : 5'sd0) - w_diff;
    end else begin
      w_sym     = {1'b0, r_qm[8], r_qm[7:0]};
      w_cnt_nxt = r_cnt + w_diff - (r_qm[8] ? 5'sd0 : 5'sd2);
    end
  end

  generate
    if (OUT_LSB_FIRST) begin : g_lsb_first
      assign w_sym_out  = w_sym;
      assign w_ctrl_rst = CTRL_00;
    end else begin : g_msb_first
      for (genvar gi = 0; gi < SYM_W; gi++) begin : g_rev
        assign w_sym_out[gi]  = w_sym[SYM_W-1-gi];
        assign w_ctrl_rst[gi] = CTRL_00[SYM_W-1-gi];
      end
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= 5'sd0;
      r_tmds <= w_ctrl_rst;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tmds <= w_sym_out;
    end
  end

  assign o_tmds = r_tmds;

`ifdef TMDS_ENCODER_DBG_EN
  assign o_disparity = r_cnt;

  a_cnt_bound: assert property (@(posedge i_clk) (r_cnt <= 5'sd10) && (r_cnt >= -5'sd10));
`endif

endmodule
`default_nettype wire
